// File: rtl/booth_mult_sequencer.sv
// Sequencer for a signed WIDTH x WIDTH radix-2 Booth multiply that borrows the
// shared carry-select adder through a request/grant handshake.
//
// state  | meaning
// IDLE   | waiting for ctrl_mult
// RUN    | one Booth iteration per granted adder cycle
// DONE   | one-cycle result strobe, may restart immediately
module booth_mult_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_mult,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             add_req,
   input  logic             add_gnt,
   output logic [WIDTH-1:0] add_in0,
   output logic [WIDTH-1:0] add_in1,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_out,
   input  logic             add_overflow,
   output logic             busy,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic             qm1_q, qm1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             exc_q, exc_d;

   logic             sum_sign;
   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] q_shift;

   // The 33rd sum bit is recovered from the adder's overflow flag, so the
   // arithmetic shift stays exact even for M = most-negative value.
   assign sum_sign = add_out[WIDTH-1] ^ add_overflow;
   assign a_shift  = {sum_sign, add_out[WIDTH-1:1]};
   assign q_shift  = {add_out[0], q_q[WIDTH-1:1]};

   assign add_in0        = a_q;
   assign data_result    = res_q;
   assign data_exception = exc_q;

   always_comb begin
      state_d        = state_q;
      a_d            = a_q;
      q_d            = q_q;
      m_d            = m_q;
      qm1_d          = qm1_q;
      cnt_d          = cnt_q;
      res_d          = res_q;
      exc_d          = exc_q;
      add_req        = 1'b0;
      add_in1        = '0;
      add_cin        = 1'b0;
      busy           = 1'b0;
      data_resultRDY = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ctrl_mult) begin
               state_d = S_RUN;
               m_d     = operand_a;
               q_d     = operand_b;
               a_d     = '0;
               qm1_d   = 1'b0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            add_req = 1'b1;
            busy    = 1'b1;
            case ({q_q[0], qm1_q})
               2'b01: add_in1 = m_q;
               2'b10: begin
                  add_in1 = ~m_q;
                  add_cin = 1'b1;
               end
               default: add_in1 = '0;
            endcase
            if (add_gnt) begin
               a_d   = a_shift;
               q_d   = q_shift;
               qm1_d = q_q[0];
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d = S_DONE;
                  res_d   = q_shift;
                  exc_d   = (a_shift != {WIDTH{q_shift[WIDTH-1]}});
               end
            end
         end
         S_DONE: begin
            data_resultRDY = 1'b1;
            if (ctrl_mult) begin
               state_d = S_RUN;
               m_d     = operand_a;
               q_d     = operand_b;
               a_d     = '0;
               qm1_d   = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         q_q     <= '0;
         m_q     <= '0;
         qm1_q   <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         q_q     <= q_d;
         m_q     <= m_d;
         qm1_q   <= qm1_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end

endmodule

// File: doc/booth_mult_sequencer.md
Name: booth_mult_sequencer

Overview:
- Multi-cycle signed 32x32 multiplier controller built around the team's shared 32-bit carry-select adder.
- Does not contain the adder itself. It drives the adder inputs, reads back the sum and overflow, and runs radix-2 Booth recoding for 32 iterations.
- The adder is shared with other datapath users, so every adder use is gated by a request/grant handshake.
- Sits beside the ALU in the execute stage and feeds the multiply writeback path.

Parameters:
- WIDTH, 32, operand/result width; must match the shared adder width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ctrl_mult  input  1  start pulse; sampled on a clock edge.
- operand_a  input  WIDTH  multiplicand M, captured when a start is accepted.
- operand_b  input  WIDTH  multiplier Q, captured when a start is accepted.
- add_req  output  1  request for the shared adder.
- add_gnt  input  1  grant for the shared adder, same cycle as the request.
- add_in0  output  WIDTH  adder operand 0 (the A register).
- add_in1  output  WIDTH  adder operand 1 (M, ~M, or 0).
- add_cin  output  1  adder carry-in.
- add_out  input  WIDTH  adder sum, combinational return.
- add_overflow  input  1  adder signed-overflow flag, combinational return.
- busy  output  1  high in the RUN state.
- data_result  output  WIDTH  low 32 bits of the product.
- data_exception  output  1  product does not fit in 32 signed bits.
- data_resultRDY  output  1  one-cycle result-valid strobe.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = IDLE; A, Q, M, q_m1 and counter cleared.
  - Outputs: add_req=0, busy=0, data_result=0, data_exception=0, data_resultRDY=0.
  - Reset mid-run aborts the operation; no RDY strobe is produced for it.
- States are IDLE, RUN and DONE.
- IDLE:
  - ctrl_mult=1 at an edge moves the block to RUN.
  - On that edge: M <= operand_a, Q <= operand_b, A <= 0, q_m1 <= 0, cnt <= 0.
- RUN:
  - add_req=1 and busy=1.
  - Booth pair {Q[0], q_m1} selects the adder operands:
    - 01: in1 = M, cin = 0.
    - 10: in1 = ~M, cin = 1.
    - 00 or 11: in1 = 0, cin = 0.
  - add_in0 = A in every case.
- Iteration update, on an edge with add_gnt=1 only:
  - s = add_out[31] XOR add_overflow, the true sign of the 33-bit sum.
  - A <= {s, add_out[31:1]}.
  - Q <= {add_out[0], Q[31:1]}.
  - q_m1 <= Q[0].
  - cnt <= cnt + 1.
- Edge with add_gnt=0 during RUN:
  - All registers hold; this is a stall.
  - add_req stays high and add_in0/add_in1/add_cin stay stable.
- After the 32nd granted iteration (cnt = 31 with add_gnt=1), the next state is DONE.
- DONE is exactly one cycle:
  - data_resultRDY = 1; data_result = Q (the final low word).
  - data_exception = 1 iff A differs from a 32-bit replication of Q[31].
  - add_req=0, busy=0.
- Result hold:
  - data_result and data_exception are registered.
  - They hold their values until the next DONE or reset.
- Back-to-back operation:
  - ctrl_mult=1 in DONE starts a new operation directly; DONE goes to RUN.
  - Otherwise DONE goes to IDLE.
- ctrl_mult during RUN is ignored; operands are not re-captured.
- Latency with add_gnt constantly 1:
  - Start accepted at edge 0.
  - Iterations occur at edges 1..32.
  - data_resultRDY is high in the cycle following edge 32, i.e. 33 cycles after acceptance.
  - Each stalled cycle adds exactly one cycle.
- Adder outputs are consumed only in RUN. add_out and add_overflow are ignored when add_gnt=0.
- The product is full signed 64-bit internally. The block raises no error on M = 0x80000000; the extra sign bit handles it.

Test Plan:
- 3 x 5, add_gnt tied 1 -> data_resultRDY high for 1 cycle, 33 cycles after start; data_result=0x0000000F; data_exception=0.
- 0xFFFFFFF9 (-7) x 6 -> data_result=0xFFFFFFD6 (-42); data_exception=0.
- 0x7FFFFFFF x 2 -> data_result=0xFFFFFFFE, data_exception=1. Then 0x80000000 x 0xFFFFFFFF -> data_result=0x80000000, data_exception=1. Then 0x80000000 x 0x80000000 -> data_result=0x00000000, data_exception=1.
- 12 x -12 with add_gnt driven 0 for 10 cycles starting at iteration 8 -> add_req stays 1 and adder inputs stay constant during the stall; RDY arrives 43 cycles after start; data_result=0xFFFFFF70.
- ctrl_mult pulsed again at RUN iteration 5 with different operands -> that pulse is ignored and the first result is correct. ctrl_mult asserted in the DONE cycle -> second operation's RDY arrives 33 cycles later with the correct product.
- reset_n pulled low at iteration 20 -> all outputs return to 0 immediately (asynchronously) and no RDY strobe occurs. After release, 2 x 2 -> data_result=4.
